// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl: kernel bank, window issue gating and outstanding-result tracking for the 3x3 convolution core.
// in_y is 11 bits wide so the last frame line (1079) is addressable.
module conv_sched_ctrl #(
    parameter int IMG_W   = 1920,
    parameter int IMG_H   = 1080,
    parameter int MAX_OUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        kernel_sel,
    input  logic              stride2,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_kidx,
    input  logic [3:0]        cfg_tap,
    input  logic [7:0]        cfg_data,
    input  logic              in_window_valid,
    input  logic [10:0]       in_x,
    input  logic [10:0]       in_y,
    input  logic              conv_valid,
    output logic              fsm_window_valid,
    output logic signed [7:0] K00,
    output logic signed [7:0] K01,
    output logic signed [7:0] K02,
    output logic signed [7:0] K10,
    output logic signed [7:0] K11,
    output logic signed [7:0] K12,
    output logic signed [7:0] K20,
    output logic signed [7:0] K21,
    output logic signed [7:0] K22,
    output logic              busy,
    output logic              done,
    output logic [20:0]       issued_count,
    output logic [20:0]       result_count,
    output logic              overrun,
    output logic              cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] bank [4][9];
    logic [7:0] k_q [9];
    logic       s2_q;
    logic [3:0] outst, outst_nx;
    logic       in_frame, cand, issue, drop, res_ok, last, accept, cfg_ok, cfg_bad;
    always_comb begin
        in_frame = in_x >= 11'd2 && in_y >= 11'd2 && in_x <= 11'(IMG_W - 1) && in_y <= 11'(IMG_H - 1)
                   && (!s2_q || (!in_x[0] && !in_y[0]));
        cand     = state == RUN && in_window_valid && in_frame;
        issue    = cand && outst < 4'(MAX_OUT);
        drop     = cand && !issue;
        res_ok   = conv_valid && outst != 4'd0 && state != IDLE;
        last     = state == RUN && in_window_valid && in_x == 11'(IMG_W - 1) && in_y == 11'(IMG_H - 1);
        accept   = state == IDLE && start;
        cfg_ok   = cfg_we && state == IDLE && cfg_tap <= 4'd8;
        cfg_bad  = cfg_we && !cfg_ok;
        outst_nx = outst + {3'b0, issue} - {3'b0, res_ok};
        state_nx = accept                                ? RUN   :
                   (state == RUN && last)                ? DRAIN :
                   (state == DRAIN && outst_nx == 4'd0)  ? DONE  :
                   (state == DONE)                       ? IDLE  : state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            outst        <= '0;
            s2_q         <= 1'b0;
            issued_count <= '0;
            result_count <= '0;
            overrun      <= 1'b0;
            cfg_err      <= 1'b0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 9; j++)
                    bank[i][j] <= '0;
            for (int i = 0; i < 9; i++)
                k_q[i] <= '0;
        end else begin
            state <= state_nx;
            outst <= outst_nx;
            if (accept) begin
                s2_q <= stride2;
                for (int i = 0; i < 9; i++)
                    k_q[i] <= bank[kernel_sel][i];
            end
            if (cfg_ok)
                bank[cfg_kidx][cfg_tap] <= cfg_data;
            issued_count <= accept ? '0 : issued_count + 21'(issue);
            result_count <= accept ? '0 : result_count + 21'(res_ok);
            overrun      <= !accept && (overrun || drop);
            cfg_err      <= (cfg_err && !accept) || cfg_bad;
        end
    end
    assign fsm_window_valid = issue;
    assign busy = state == RUN || state == DRAIN;
    assign done = state == DONE;
    assign K00 = k_q[0];
    assign K01 = k_q[1];
    assign K02 = k_q[2];
    assign K10 = k_q[3];
    assign K11 = k_q[4];
    assign K12 = k_q[5];
    assign K20 = k_q[6];
    assign K21 = k_q[7];
    assign K22 = k_q[8];
endmodule

// File: tb/tb_conv_sched_ctrl.sv
// tb_conv_sched_ctrl: vector table, directed corner sequences and random stimulus against a frame-level reference model.
module tb_conv_sched_ctrl;
    logic        clk, reset, start, stride2, cfg_we, in_window_valid, conv_valid;
    logic [1:0]  kernel_sel, cfg_kidx;
    logic [3:0]  cfg_tap;
    logic [7:0]  cfg_data;
    logic [10:0] in_x, in_y;
    logic        fsm_window_valid, busy, done, overrun, cfg_err;
    logic [20:0] issued_count, result_count;
    logic [8:0][7:0] kp;
    int nerr = 0, nchk = 0;

    conv_sched_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .kernel_sel(kernel_sel), .stride2(stride2),
        .cfg_we(cfg_we), .cfg_kidx(cfg_kidx), .cfg_tap(cfg_tap), .cfg_data(cfg_data),
        .in_window_valid(in_window_valid), .in_x(in_x), .in_y(in_y), .conv_valid(conv_valid),
        .fsm_window_valid(fsm_window_valid),
        .K00(kp[0]), .K01(kp[1]), .K02(kp[2]), .K10(kp[3]), .K11(kp[4]), .K12(kp[5]),
        .K20(kp[6]), .K21(kp[7]), .K22(kp[8]),
        .busy(busy), .done(done), .issued_count(issued_count), .result_count(result_count),
        .overrun(overrun), .cfg_err(cfg_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: frame phase 0=idle 1=running 2=draining 3=finished
    int m_phase, m_out, m_iss, m_res;
    bit m_ovr, m_cerr, m_s2;
    bit [7:0] m_bank [4][9];
    bit [7:0] m_k [9];

    task automatic m_reset();
        m_phase = 0; m_out = 0; m_iss = 0; m_res = 0; m_ovr = 0; m_cerr = 0; m_s2 = 0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 9; j++) m_bank[i][j] = 0;
        for (int j = 0; j < 9; j++) m_k[j] = 0;
    endtask

    function automatic bit m_fits(int x, int y);
        return x >= 2 && y >= 2 && x <= 1919 && y <= 1079 && (!m_s2 || (x % 2 == 0 && y % 2 == 0));
    endfunction

    function automatic bit m_fwv();
        return m_phase == 1 && in_window_valid && m_fits(int'(in_x), int'(in_y)) && m_out < 15;
    endfunction

    task automatic m_step();
        bit iss, drop, res, last, bad;
        iss  = m_fwv();
        drop = m_phase == 1 && in_window_valid && m_fits(int'(in_x), int'(in_y)) && m_out >= 15;
        res  = conv_valid && m_out > 0 && m_phase != 0;
        last = m_phase == 1 && in_window_valid && in_x == 1919 && in_y == 1079;
        bad  = cfg_we && !(m_phase == 0 && cfg_tap <= 8);
        if (m_phase == 0 && start) begin
            for (int j = 0; j < 9; j++) m_k[j] = m_bank[kernel_sel][j];
            m_s2 = stride2; m_iss = 0; m_res = 0; m_ovr = 0; m_cerr = 0;
        end else begin
            m_iss += int'(iss); m_res += int'(res); m_ovr |= drop;
        end
        m_cerr |= bad;
        if (cfg_we && !bad) m_bank[cfg_kidx][cfg_tap] = cfg_data;
        m_out = m_out + int'(iss) - int'(res);
        case (m_phase)
            0: if (start) m_phase = 1;
            1: if (last) m_phase = 2;
            2: if (m_out == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("fwv", 32'(fsm_window_valid), 32'(m_fwv()));
        chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("issued", 32'(issued_count), m_iss);
        chk("results", 32'(result_count), m_res);
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("cfg_err", 32'(cfg_err), 32'(m_cerr));
        for (int j = 0; j < 9; j++) chk($sformatf("K%0d", j), 32'(kp[j]), 32'(m_k[j]));
    endtask

    task automatic cyc();
        #2;
        chk_all();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic win(bit v, int x, int y);
        in_window_valid = v; in_x = 11'(x); in_y = 11'(y);
    endtask

    task automatic go(int ks, bit s2);
        start = 1; kernel_sel = 2'(ks); stride2 = s2;
        cyc();
        start = 0;
    endtask

    task automatic drain();
        int n = 0;
        win(1, 1919, 1079);
        cyc();
        win(0, 0, 0);
        conv_valid = 1;
        while (done !== 1'b1 && n < 40) begin cyc(); n++; end
        conv_valid = 0;
        chk("drain_done", 32'(done), 1);
        cyc();
    endtask

    typedef struct { bit v; int x; int y; bit fwv; int iss; } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 5, 5, 1, 1};
        tbl[1]  = '{1, 1, 5, 0, 1};
        tbl[2]  = '{1, 5, 1, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 1};
        tbl[4]  = '{0, 5, 5, 0, 1};
        tbl[5]  = '{1, 2, 2, 1, 2};
        tbl[6]  = '{1, 1919, 1078, 1, 3};
        tbl[7]  = '{1, 1920, 5, 0, 3};
        tbl[8]  = '{1, 5, 1080, 0, 3};
        tbl[9]  = '{1, 2047, 1023, 0, 3};
        tbl[10] = '{1, 1919, 2, 1, 4};
        tbl[11] = '{1, 3, 1079, 1, 5};

        reset = 0; start = 0; kernel_sel = 0; stride2 = 0; cfg_we = 0; cfg_kidx = 0;
        cfg_tap = 0; cfg_data = 0; conv_valid = 0;
        win(0, 0, 0);
        m_reset();
        #3;
        chk_all();
        @(posedge clk);
        #1 reset = 1;

        // bank load: kernel 1 all ones, others random
        cfg_we = 1;
        for (int k = 0; k < 4; k++)
            for (int t = 0; t < 9; t++) begin
                cfg_kidx = 2'(k); cfg_tap = 4'(t); cfg_data = (k == 1) ? 8'd1 : 8'($urandom);
                cyc();
            end
        cfg_we = 0;
        go(1, 0);
        for (int j = 0; j < 9; j++) chk("k1_load", 32'(kp[j]), 1);
        chk("run_busy", 32'(busy), 1);

        foreach (tbl[i]) begin
            win(tbl[i].v, tbl[i].x, tbl[i].y);
            #1;
            chk($sformatf("tbl%0d_fwv", i), 32'(fsm_window_valid), 32'(tbl[i].fwv));
            cyc();
            chk($sformatf("tbl%0d_iss", i), 32'(issued_count), tbl[i].iss);
        end
        drain();

        // stride 2
        go(2, 1);
        win(1, 4, 4); #1; chk("s2_44", 32'(fsm_window_valid), 1); cyc();
        win(1, 5, 4); #1; chk("s2_54", 32'(fsm_window_valid), 0); cyc();
        win(1, 4, 5); #1; chk("s2_45", 32'(fsm_window_valid), 0); cyc();
        chk("s2_iss", 32'(issued_count), 1);
        drain();

        // 16 issues without results
        go(0, 0);
        for (int i = 0; i < 16; i++) begin win(1, 10, 10); cyc(); end
        chk("ovr_iss", 32'(issued_count), 15);
        chk("ovr_flag", 32'(overrun), 1);
        drain();

        // final window with 3 in flight, results 3 cycles later
        go(0, 0);
        win(1, 6, 6); cyc();
        win(1, 8, 8); cyc();
        win(1, 1919, 1079); cyc();
        win(0, 0, 0);
        chk("drain_busy", 32'(busy), 1);
        cyc(); cyc();
        chk("drain_wait", 32'(done), 0);
        conv_valid = 1;
        cyc(); cyc();
        chk("drain_not_yet", 32'(done), 0);
        cyc();
        conv_valid = 0;
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_iss", 32'(issued_count), 3);
        chk("fin_res", 32'(result_count), 3);
        cyc();
        chk("done_pulse", 32'(done), 0);

        // rejected writes
        cfg_we = 1; cfg_kidx = 0; cfg_tap = 9; cfg_data = 8'h55;
        cyc();
        cfg_we = 0;
        chk("tap9_err", 32'(cfg_err), 1);
        go(0, 0);
        chk("err_clr", 32'(cfg_err), 0);
        cfg_we = 1; cfg_tap = 0; cfg_data = 8'h7f;
        win(1, 5, 5);
        cyc();
        cfg_we = 0;
        chk("run_err", 32'(cfg_err), 1);
        chk("run_iss", 32'(issued_count), 1);

        // asynchronous reset mid-frame
        reset = 0;
        #1;
        m_reset();
        chk("rst_fwv", 32'(fsm_window_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_iss", 32'(issued_count), 0);
        chk("rst_err", 32'(cfg_err), 0);
        for (int j = 0; j < 9; j++) chk("rst_k", 32'(kp[j]), 0);
        @(posedge clk);
        #1 reset = 1;
        win(0, 0, 0);

        // start and write in the same cycle: K loads the pre-write value
        cfg_we = 1; cfg_kidx = 3; cfg_tap = 0; cfg_data = 8'h11;
        go(3, 0);
        cfg_we = 0;
        chk("sw_old", 32'(kp[0]), 0);
        drain();
        go(3, 0);
        chk("sw_new", 32'(kp[0]), 32'h11);
        drain();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom % 8) == 0;
            kernel_sel = 2'($urandom); stride2 = 1'($urandom);
            cfg_we = ($urandom % 4) == 0;
            cfg_kidx = 2'($urandom); cfg_tap = 4'($urandom_range(0, 10)); cfg_data = 8'($urandom);
            win(($urandom % 10) < 7,
                ($urandom % 8 == 0) ? int'($urandom_range(1915, 2047)) : int'($urandom_range(0, 20)),
                ($urandom % 8 == 0) ? int'($urandom_range(1070, 1100)) : int'($urandom_range(0, 20)));
            if (m_phase == 1 && ($urandom % 150) == 0) win(1, 1919, 1079);
            conv_valid = ($urandom % 10) < 4;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
